// File: rtl/matvec_pkg.sv
// Shared definitions for the matrix-vector MAC engine: FSM encoding, accumulator sizing and
// output saturation.
package matvec_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

   localparam int unsigned SAT_W     = 64;
   localparam int unsigned SAT_OUT_W = 32;

   function automatic int unsigned acc_width(input int unsigned data_size,
                                             input int unsigned column_size);
      return 2 * data_size + $clog2(column_size) + 1;
   endfunction

   // Callers pass the accumulator already sign- or zero-extended to SAT_W bits.
   function automatic logic [SAT_OUT_W-1:0] saturate(input logic signed [SAT_W-1:0] value,
                                                      input int unsigned data_size,
                                                      input bit is_signed);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      if (is_signed) begin
         hi = (64'sd1 <<< (data_size - 1)) - 64'sd1;
         lo = -(64'sd1 <<< (data_size - 1));
      end else begin
         hi = (64'sd1 <<< data_size) - 64'sd1;
         lo = 64'sd0;
      end
      if (value > hi) begin
         return SAT_OUT_W'(hi);
      end else if (value < lo) begin
         return SAT_OUT_W'(lo);
      end
      return SAT_OUT_W'(value);
   endfunction

endpackage

// File: rtl/matvec_lane_mul.sv
// One multiply-and-shift lane: full-precision product truncated by FRAC_BITS.
module matvec_lane_mul #(
   parameter int unsigned DATA_SIZE = 16,
   parameter int unsigned FRAC_BITS = 16,
   parameter int unsigned SIGNED    = 0
) (
   input  logic [DATA_SIZE-1:0]   a,
   input  logic [DATA_SIZE-1:0]   b,
   output logic [2*DATA_SIZE-1:0] product
);

   localparam int unsigned PROD_W = 2 * DATA_SIZE;

   if (SIGNED != 0) begin : g_signed
      logic signed [PROD_W-1:0] a_ext;
      logic signed [PROD_W-1:0] b_ext;
      logic signed [PROD_W-1:0] full;
      assign a_ext   = PROD_W'($signed(a));
      assign b_ext   = PROD_W'($signed(b));
      assign full    = a_ext * b_ext;
      assign product = full >>> FRAC_BITS;
   end else begin : g_unsigned
      logic [PROD_W-1:0] a_ext;
      logic [PROD_W-1:0] b_ext;
      logic [PROD_W-1:0] full;
      assign a_ext   = PROD_W'(a);
      assign b_ext   = PROD_W'(b);
      assign full    = a_ext * b_ext;
      assign product = full >> FRAC_BITS;
   end

endmodule

// File: rtl/matvec_mac_engine.sv
// Streaming matrix-vector multiply: latched vector A times row-major matrix beats, one
// saturated dot product per row through a two-stage multiply / accumulate pipeline.
module matvec_mac_engine
   import matvec_pkg::*;
#(
   parameter int unsigned DATA_SIZE   = 16,
   parameter int unsigned COLUMN_SIZE = 64,
   parameter int unsigned ROW_SIZE    = 64,
   parameter int unsigned LANES       = 8,
   parameter int unsigned FRAC_BITS   = 16,
   parameter int unsigned SIGNED      = 0,
   localparam int unsigned IDX_W      = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             vec_valid,
   output logic                             vec_ready,
   input  logic [DATA_SIZE*COLUMN_SIZE-1:0] vec_data,
   input  logic                             mat_valid,
   output logic                             mat_ready,
   input  logic [DATA_SIZE*LANES-1:0]       mat_data,
   output logic                             res_valid,
   input  logic                             res_ready,
   output logic [DATA_SIZE-1:0]             res_data,
   output logic [IDX_W-1:0]                 res_index,
   output logic                             busy,
   output logic                             done
);

   localparam int unsigned BEATS  = COLUMN_SIZE / LANES;
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned PROD_W = 2 * DATA_SIZE;
   localparam int unsigned ACC_W  = acc_width(DATA_SIZE, COLUMN_SIZE);

   state_e                           state_q, state_d;
   logic [BEAT_W-1:0]                beat_q;
   logic [IDX_W-1:0]                 row_q;
   logic [DATA_SIZE*COLUMN_SIZE-1:0] vec_q;
   logic                             stall, vec_fire, mat_fire, res_fire;
   logic                             last_beat, last_row, s2_en;
   logic [PROD_W-1:0]                prod      [LANES];
   logic [PROD_W-1:0]                s1_prod_q [LANES];
   logic                             s1_valid_q, s1_last_q, s1_first_q;
   logic [IDX_W-1:0]                 s1_row_q;
   logic [ACC_W-1:0]                 acc_q, acc_d, lane_sum;
   logic signed [SAT_W-1:0]          acc_ext;
   logic [DATA_SIZE-1:0]             res_data_d;
   logic                             res_valid_q;
   logic [DATA_SIZE-1:0]             res_data_q;
   logic [IDX_W-1:0]                 res_index_q;

   assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
   assign last_row  = (row_q == IDX_W'(ROW_SIZE - 1));
   assign stall     = res_valid_q && !res_ready;
   assign vec_ready = (state_q == StIdle) && !reset;
   assign mat_ready = (state_q == StRun) && !stall && !reset;
   assign vec_fire  = vec_valid && vec_ready;
   assign mat_fire  = mat_valid && mat_ready;
   assign res_fire  = res_valid_q && res_ready;
   assign s2_en     = s1_valid_q && !stall;

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_index = res_index_q;
   assign busy      = (state_q != StIdle);
   assign done      = res_fire && (state_q == StFlush) && (res_index_q == IDX_W'(ROW_SIZE - 1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (vec_fire) state_d = StRun;
         StRun:   if (mat_fire && last_beat && last_row) state_d = StFlush;
         StFlush: if (done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         beat_q  <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         if (mat_fire) begin
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
            if (last_beat) row_q <= last_row ? '0 : row_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (vec_fire) vec_q <= vec_data;
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [DATA_SIZE-1:0] a_sel;
      assign a_sel = vec_q[(int'(beat_q) * LANES + l) * DATA_SIZE +: DATA_SIZE];
      matvec_lane_mul #(
         .DATA_SIZE (DATA_SIZE),
         .FRAC_BITS (FRAC_BITS),
         .SIGNED    (SIGNED)
      ) u_mul (
         .a       (a_sel),
         .b       (mat_data[l*DATA_SIZE +: DATA_SIZE]),
         .product (prod[l])
      );
   end

   // Stage 1 only advances when the result register can accept; otherwise everything freezes.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_first_q <= 1'b0;
         s1_row_q   <= '0;
         for (int l = 0; l < LANES; l++) s1_prod_q[l] <= '0;
      end else if (!stall) begin
         s1_valid_q <= mat_fire;
         s1_last_q  <= last_beat;
         s1_first_q <= (beat_q == '0);
         s1_row_q   <= row_q;
         for (int l = 0; l < LANES; l++) s1_prod_q[l] <= prod[l];
      end
   end

   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < LANES; l++) begin
         if (SIGNED != 0) lane_sum = lane_sum + ACC_W'($signed(s1_prod_q[l]));
         else             lane_sum = lane_sum + ACC_W'(s1_prod_q[l]);
      end
      acc_d = s1_first_q ? lane_sum : acc_q + lane_sum;
      if (SIGNED != 0) acc_ext = SAT_W'($signed(acc_d));
      else             acc_ext = SAT_W'(acc_d);
      res_data_d = DATA_SIZE'(saturate(acc_ext, DATA_SIZE, SIGNED != 0));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_index_q <= '0;
      end else begin
         if (s2_en) acc_q <= acc_d;
         if (s2_en && s1_last_q) begin
            res_valid_q <= 1'b1;
            res_data_q  <= res_data_d;
            res_index_q <= s1_row_q;
         end else if (res_fire) begin
            res_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_matvec_mac_engine.sv
// Table-driven bench: an unsigned (FRAC 16) and a signed (FRAC 15) engine share stimulus.
module tb_matvec_mac_engine;

   localparam int unsigned DW    = 16;
   localparam int unsigned COLS  = 8;
   localparam int unsigned ROWS  = 4;
   localparam int unsigned LN    = 4;
   localparam int unsigned BEATS = COLS / LN;
   localparam int unsigned NB    = ROWS * BEATS;

   typedef struct packed {
      logic [DW*COLS-1:0]          vec;
      logic [NB-1:0][DW*LN-1:0]    mat;
      logic [ROWS-1:0][DW-1:0]     exp_u;
      logic [ROWS-1:0][DW-1:0]     exp_s;
   } vec_t;

   logic               clock = 1'b0;
   logic               reset;
   logic               vec_valid, mat_valid, res_ready;
   logic [DW*COLS-1:0] vec_data;
   logic [DW*LN-1:0]   mat_data;

   logic          vr_u, mr_u, rv_u, busy_u, done_u;
   logic [DW-1:0] rd_u;
   logic [1:0]    ri_u;
   logic          vr_s, mr_s, rv_s, busy_s, done_s;
   logic [DW-1:0] rd_s;
   logic [1:0]    ri_s;

   vec_t tbl [6];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clock = ~clock;

   matvec_mac_engine #(
      .DATA_SIZE(DW), .COLUMN_SIZE(COLS), .ROW_SIZE(ROWS), .LANES(LN),
      .FRAC_BITS(16), .SIGNED(0)
   ) u_dut_u (
      .clock(clock), .reset(reset),
      .vec_valid(vec_valid), .vec_ready(vr_u), .vec_data(vec_data),
      .mat_valid(mat_valid), .mat_ready(mr_u), .mat_data(mat_data),
      .res_valid(rv_u), .res_ready(res_ready), .res_data(rd_u), .res_index(ri_u),
      .busy(busy_u), .done(done_u)
   );

   matvec_mac_engine #(
      .DATA_SIZE(DW), .COLUMN_SIZE(COLS), .ROW_SIZE(ROWS), .LANES(LN),
      .FRAC_BITS(15), .SIGNED(1)
   ) u_dut_s (
      .clock(clock), .reset(reset),
      .vec_valid(vec_valid), .vec_ready(vr_s), .vec_data(vec_data),
      .mat_valid(mat_valid), .mat_ready(mr_s), .mat_data(mat_data),
      .res_valid(rv_s), .res_ready(res_ready), .res_data(rd_s), .res_index(ri_s),
      .busy(busy_s), .done(done_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic vec_t uni(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] eu, input logic [15:0] es);
      vec_t t;
      for (int k = 0; k < COLS; k++) t.vec[k*DW +: DW] = a;
      for (int n = 0; n < NB; n++)
         for (int l = 0; l < LN; l++) t.mat[n][l*DW +: DW] = b;
      for (int r = 0; r < ROWS; r++) begin
         t.exp_u[r] = eu;
         t.exp_s[r] = es;
      end
      return t;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, " vec_ready_u"}, vr_u, 0);   check({tag, " vec_ready_s"}, vr_s, 0);
      check({tag, " mat_ready_u"}, mr_u, 0);   check({tag, " mat_ready_s"}, mr_s, 0);
      check({tag, " res_valid_u"}, rv_u, 0);   check({tag, " res_valid_s"}, rv_s, 0);
      check({tag, " res_data_u"}, rd_u, 0);    check({tag, " res_data_s"}, rd_s, 0);
      check({tag, " res_index_u"}, ri_u, 0);   check({tag, " res_index_s"}, ri_s, 0);
      check({tag, " busy_u"}, busy_u, 0);      check({tag, " busy_s"}, busy_s, 0);
      check({tag, " done_u"}, done_u, 0);      check({tag, " done_s"}, done_s, 0);
   endtask

   task automatic run_entry(input int idx, input bit stall, input bit vec_hold);
      vec_t t;
      int   ptr, got, hold, cyc, dcnt_u, dcnt_s;
      bit   stalled_once;
      t = tbl[idx];
      ptr = 0; got = 0; hold = 0; cyc = 0; dcnt_u = 0; dcnt_s = 0; stalled_once = 0;
      res_ready = 1'b1;
      @(negedge clock);
      vec_data  = t.vec;
      vec_valid = 1'b1;
      #1;
      check($sformatf("r%0d vec_ready_u idle", idx), vr_u, 1);
      check($sformatf("r%0d vec_ready_s idle", idx), vr_s, 1);
      @(negedge clock);
      vec_valid = vec_hold;
      vec_data  = ~t.vec;
      #1;
      check($sformatf("r%0d busy_u run", idx), busy_u, 1);
      check($sformatf("r%0d busy_s run", idx), busy_s, 1);
      while (got < ROWS && cyc < 200) begin
         @(negedge clock);
         cyc++;
         mat_valid = (ptr < NB);
         mat_data  = (ptr < NB) ? t.mat[ptr] : '0;
         if (stall && !stalled_once && rv_u) begin
            hold = 5;
            stalled_once = 1;
         end
         res_ready = (hold == 0);
         #1;
         if (hold > 0) begin
            check($sformatf("r%0d stall mat_ready", idx), mr_u, 0);
            check($sformatf("r%0d stall res_valid", idx), rv_u, 1);
            check($sformatf("r%0d stall res_data", idx), rd_u, t.exp_u[got]);
            check($sformatf("r%0d stall res_index", idx), ri_u, got);
            hold--;
         end
         if (vec_hold) check($sformatf("r%0d vec_ready in run", idx), vr_u, 0);
         if (done_u) dcnt_u++;
         if (done_s) dcnt_s++;
         if (rv_u && res_ready) begin
            check($sformatf("r%0d row%0d res_data_u", idx, got), rd_u, t.exp_u[got]);
            check($sformatf("r%0d row%0d res_index_u", idx, got), ri_u, got);
            check($sformatf("r%0d row%0d res_valid_s", idx, got), rv_s, 1);
            check($sformatf("r%0d row%0d res_data_s", idx, got), rd_s, t.exp_s[got]);
            check($sformatf("r%0d row%0d res_index_s", idx, got), ri_s, got);
            check($sformatf("r%0d row%0d done_u", idx, got), done_u, (got == ROWS - 1));
            got++;
         end
         if (mat_valid && mr_u) ptr++;
      end
      mat_valid = 1'b0;
      vec_valid = 1'b0;
      res_ready = 1'b1;
      check($sformatf("r%0d results received", idx), got, ROWS);
      check($sformatf("r%0d beats accepted", idx), ptr, NB);
      check($sformatf("r%0d done_u pulses", idx), dcnt_u, 1);
      check($sformatf("r%0d done_s pulses", idx), dcnt_s, 1);
      @(negedge clock);
      #1;
      check($sformatf("r%0d busy_u after", idx), busy_u, 0);
      check($sformatf("r%0d busy_s after", idx), busy_s, 0);
      check($sformatf("r%0d vec_ready_u after", idx), vr_u, 1);
      check($sformatf("r%0d res_valid_u after", idx), rv_u, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = uni(16'h1000, 16'h1000, 16'h0800, 16'h1000);
      tbl[1] = uni(16'h8000, 16'h8000, 16'hFFFF, 16'h7FFF);
      tbl[2] = uni(16'h4000, 16'hC000, 16'hFFFF, 16'h8000);
      tbl[3] = uni(16'h4000, 16'h0400, 16'h0800, 16'h1000);
      tbl[4] = uni(16'h0003, 16'hFFFF, 16'h0010, 16'hFFF8);
      // Ramp vector; only beat 0 of each row is non-zero, scaled by row number.
      tbl[5] = uni(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      for (int k = 0; k < COLS; k++) tbl[5].vec[k*DW +: DW] = 16'((k + 1) * 256);
      for (int r = 0; r < ROWS; r++) begin
         tbl[5].mat[r*BEATS] = {LN{16'((r + 1) * 256)}};
         tbl[5].exp_u[r]     = 16'(10 * (r + 1));
         tbl[5].exp_s[r]     = 16'(20 * (r + 1));
      end

      reset = 1'b1; vec_valid = 1'b0; mat_valid = 1'b0; res_ready = 1'b1;
      vec_data = '0; mat_data = '0;
      repeat (3) @(negedge clock);
      #1;
      check_reset_outputs("por");
      reset = 1'b0;
      @(negedge clock);
      #1;
      check("por vec_ready released", vr_u, 1);
      check("por busy released", busy_u, 0);

      mat_valid = 1'b1;
      mat_data  = 64'hDEAD_BEEF_1234_5678;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         #1;
         check("idle mat_ready_u", mr_u, 0);
         check("idle busy_u", busy_u, 0);
      end
      mat_valid = 1'b0;

      run_entry(0, 0, 0);
      run_entry(1, 0, 0);
      run_entry(2, 0, 1);
      run_entry(3, 1, 0);
      run_entry(4, 0, 0);
      run_entry(5, 1, 1);

      // Abort a run after one beat of row 0, then verify a clean re-run.
      @(negedge clock);
      vec_data = tbl[1].vec; vec_valid = 1'b1;
      @(negedge clock);
      vec_valid = 1'b0; mat_valid = 1'b1; mat_data = tbl[1].mat[0];
      #1;
      check("abort beat mat_ready", mr_u, 1);
      @(negedge clock);
      mat_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      #1;
      check_reset_outputs("abort");
      reset = 1'b0;
      @(negedge clock);
      #1;
      check("abort vec_ready released", vr_u, 1);
      check("abort busy released", busy_u, 0);
      run_entry(5, 0, 0);
      run_entry(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
